// File: rtl/pdm_cic_decimator.sv
// Stereo PDM to 16-bit PCM decimator: 3rd-order CIC, R = 2^DEC_LOG2.
// Output word {L,R} pushed into a native write FIFO.
module pdm_cic_decimator #(
    parameter int DEC_LOG2 = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        pdm_l,
    input  logic        pdm_r,
    output logic        wren,
    output logic [31:0] wrdat,
    input  logic        wrfull,
    output logic        ovf
);

    localparam int IW  = 2 + 3 * DEC_LOG2;
    localparam int SH  = 3 * DEC_LOG2;
    localparam int SHR = (SH > 15) ? SH - 15 : 0;
    localparam int SHL = (SH < 15) ? 15 - SH : 0;
    localparam int XW  = IW + SHL + 1;

    localparam logic [DEC_LOG2-1:0] DC_LAST = '1;
    localparam logic signed [XW-1:0] PMAX = XW'(32767);
    localparam logic signed [XW-1:0] NMIN = -XW'(32768);

    logic [DEC_LOG2-1:0] dc;
    logic [1:0]          wu;
    logic                stb;
    logic                p0;
    logic                p1;
    logic                p2;
    logic                vld;

    logic [IW-1:0] x    [2];
    logic [IW-1:0] i1   [2];
    logic [IW-1:0] i2   [2];
    logic [IW-1:0] i3   [2];
    logic [IW-1:0] v    [2];
    logic [IW-1:0] v_d  [2];
    logic [IW-1:0] c1   [2];
    logic [IW-1:0] c1_d [2];
    logic [IW-1:0] c2   [2];
    logic [IW-1:0] c2_d [2];
    logic [IW-1:0] c3   [2];
    logic signed [XW-1:0] sc [2];
    logic [15:0]   sat  [2];

    assign stb  = (dc == DC_LAST);
    assign wren = vld & en & ~wrfull;

    // Bit 1 -> +1, bit 0 -> -1; third comb and scaling to 16-bit full scale
    always_comb begin
        x[0] = pdm_l ? IW'(1) : {IW{1'b1}};
        x[1] = pdm_r ? IW'(1) : {IW{1'b1}};
        for (int ch = 0; ch < 2; ch++) begin
            c3[ch] = c2[ch] - c2_d[ch];
            sc[ch] = (XW'($signed(c3[ch])) <<< SHL) >>> SHR;
            if (sc[ch] > PMAX) begin
                sat[ch] = 16'h7fff;
            end else if (sc[ch] < NMIN) begin
                sat[ch] = 16'h8000;
            end else begin
                sat[ch] = sc[ch][15:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dc    <= '0;
            wu    <= '0;
            p0    <= 1'b0;
            p1    <= 1'b0;
            p2    <= 1'b0;
            vld   <= 1'b0;
            wrdat <= '0;
            ovf   <= 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                i1[ch]   <= '0;
                i2[ch]   <= '0;
                i3[ch]   <= '0;
                v[ch]    <= '0;
                v_d[ch]  <= '0;
                c1[ch]   <= '0;
                c1_d[ch] <= '0;
                c2[ch]   <= '0;
                c2_d[ch] <= '0;
            end
        end else begin
            if (vld && en && wrfull) begin
                ovf <= 1'b1;
            end
            if (!en) begin
                dc  <= '0;
                wu  <= '0;
                p0  <= 1'b0;
                p1  <= 1'b0;
                p2  <= 1'b0;
                vld <= 1'b0;
                for (int ch = 0; ch < 2; ch++) begin
                    i1[ch]   <= '0;
                    i2[ch]   <= '0;
                    i3[ch]   <= '0;
                    v[ch]    <= '0;
                    v_d[ch]  <= '0;
                    c1[ch]   <= '0;
                    c1_d[ch] <= '0;
                    c2[ch]   <= '0;
                    c2_d[ch] <= '0;
                end
            end else begin
                dc  <= dc + 1'b1;
                p0  <= stb;
                p1  <= p0;
                p2  <= p1;
                vld <= p2 && (wu == 2'd3);
                if (p2) begin
                    if (wu != 2'd3) begin
                        wu <= wu + 2'd1;
                    end else begin
                        wrdat <= {sat[0], sat[1]};
                    end
                end
                for (int ch = 0; ch < 2; ch++) begin
                    i1[ch] <= i1[ch] + x[ch];
                    i2[ch] <= i2[ch] + i1[ch];
                    i3[ch] <= i3[ch] + i2[ch];
                    // Capture the integrator value as updated at this edge
                    if (stb) begin
                        v[ch] <= i3[ch] + i2[ch];
                    end
                    if (p0) begin
                        c1[ch]  <= v[ch] - v_d[ch];
                        v_d[ch] <= v[ch];
                    end
                    if (p1) begin
                        c2[ch]   <= c1[ch] - c1_d[ch];
                        c1_d[ch] <= c1[ch];
                    end
                    if (p2) begin
                        c2_d[ch] <= c2[ch];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Bench for pdm_cic_decimator: closed-form CIC model checked every cycle,
// plus literal expectations from hand-worked patterns.
module tb_pdm_cic_decimator;

    localparam int D   = 5;
    localparam int R   = 1 << D;
    localparam int IW  = 2 + 3 * D;
    localparam int SH  = 3 * D;
    localparam int SHR = (SH > 15) ? SH - 15 : 0;
    localparam int SHL = (SH < 15) ? 15 - SH : 0;
    localparam int FIRST = 4 * R + 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        pdm_l;
    logic        pdm_r;
    logic        wren;
    logic [31:0] wrdat;
    logic        wrfull;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    int xl[$];
    int xr[$];
    int cyc = 0;
    logic ovf_m = 1'b0;

    int mode = 0;
    int ph = 0;

    pdm_cic_decimator #(.DEC_LOG2(D)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .pdm_l  (pdm_l),
        .pdm_r  (pdm_r),
        .wren   (wren),
        .wrdat  (wrdat),
        .wrfull (wrfull),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // i3 after t updates = sum_j x_j * C(t-1-j, 2)
    function automatic longint i3_at(input int q[$], input int t);
        longint s = 0;
        for (int j = 0; j < t; j++) begin
            longint n = t - 1 - j;
            s += q[j] * (n * (n - 1) / 2);
        end
        return s;
    endfunction

    // m-th decimated output: third difference of decimated i3, wrapped, scaled, saturated
    function automatic logic [15:0] chan(input int q[$], input int m);
        longint c;
        longint md;
        logic [63:0] b;
        c = i3_at(q, R * (m + 1)) - 3 * i3_at(q, R * m)
          + 3 * i3_at(q, R * (m - 1)) - i3_at(q, R * (m - 2));
        md = longint'(1) << IW;
        c = c % md;
        if (c < 0) c += md;
        if (c >= md / 2) c -= md;
        c = (c * (longint'(1) << SHL)) >>> SHR;
        if (c > 32767) c = 32767;
        if (c < -32768) c = -32768;
        b = c;
        return b[15:0];
    endfunction

    function automatic logic is_slot(input int c);
        return (c >= FIRST) && ((c - 3) % R == 0);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            cyc = 0;
            xl.delete();
            xr.delete();
            ovf_m = 1'b0;
        end else if (en) begin
            if (is_slot(cyc) && wrfull) ovf_m = 1'b1;
            xl.push_back(pdm_l ? 1 : -1);
            xr.push_back(pdm_r ? 1 : -1);
            cyc++;
        end else begin
            cyc = 0;
            xl.delete();
            xr.delete();
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_wren", {31'd0, wren}, 32'd0);
            chk("rst_wrdat", wrdat, 32'd0);
            chk("rst_ovf", {31'd0, ovf}, 32'd0);
        end else begin
            logic ew;
            int m;
            ew = en && is_slot(cyc) && !wrfull;
            chk("wren", {31'd0, wren}, {31'd0, ew});
            if (ew) begin
                m = (cyc - 3) / R - 1;
                chk("wrdat", wrdat, {chan(xl, m), chan(xr, m)});
            end
            chk("ovf", {31'd0, ovf}, {31'd0, ovf_m});
        end
    end

    task automatic drive();
        case (mode)
            0: begin pdm_l = 1'b1; pdm_r = 1'b1; end
            1: begin pdm_l = 1'b0; pdm_r = 1'b0; end
            2: begin pdm_l = (ph % 2 == 0); pdm_r = (ph % 4 != 3); end
            default: begin pdm_l = 1'b1; pdm_r = 1'b0; end
        endcase
        ph++;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        drive();
    endtask

    task automatic restart(input int m);
        @(posedge clk);
        #2 en = 1'b0;
        repeat (4) tick();
        @(posedge clk);
        #2 en = 1'b1;
        mode = m;
        ph = 0;
        drive();
    endtask

    task automatic first_wren(output int k);
        k = 0;
        while (k < 400) begin
            @(negedge clk);
            if (wren) break;
            k++;
            tick();
        end
    endtask

    task automatic run(input int n, output int cnt, output logic [31:0] last);
        cnt = 0;
        last = 32'hdead_beef;
        repeat (n) begin
            @(negedge clk);
            if (wren) begin
                cnt++;
                last = wrdat;
            end
            tick();
        end
    endtask

    initial begin
        int k;
        int cnt;
        logic [31:0] last;
        rst = 1'b1;
        en = 1'b0;
        wrfull = 1'b0;
        pdm_l = 1'b0;
        pdm_r = 1'b0;
        #12;
        @(posedge clk);
        #2 rst = 1'b0;
        en = 1'b1;
        mode = 0;
        ph = 0;
        drive();

        first_wren(k);
        chk("ones_first_cycle", k, FIRST);
        chk("ones_wrdat", wrdat, 32'h7fff_7fff);
        tick();
        run(96, cnt, last);
        chk("ones_rate", cnt, 3);
        chk("ones_last", last, 32'h7fff_7fff);

        wrfull = 1'b1;
        run(32, cnt, last);
        chk("full_no_wren", cnt, 0);
        wrfull = 1'b0;
        chk("full_ovf_set", {31'd0, ovf}, 32'd1);
        run(32, cnt, last);
        chk("after_full_cnt", cnt, 1);
        chk("after_full_dat", last, 32'h7fff_7fff);

        restart(1);
        first_wren(k);
        chk("zeros_first_cycle", k, FIRST);
        chk("zeros_wrdat", wrdat, 32'h8000_8000);
        chk("ovf_kept_by_en", {31'd0, ovf}, 32'd1);

        restart(2);
        first_wren(k);
        chk("pat_first_cycle", k, FIRST);
        tick();
        run(64, cnt, last);
        chk("pat_cnt", cnt, 2);
        chk("pat_last", last, 32'h0000_4000);

        restart(3);
        first_wren(k);
        chk("lr_first_cycle", k, FIRST);
        chk("lr_wrdat", wrdat, 32'h7fff_8000);

        tick();
        run(29, cnt, last);
        #1 rst = 1'b1;
        #1;
        chk("arst_wren", {31'd0, wren}, 32'd0);
        chk("arst_wrdat", wrdat, 32'd0);
        chk("arst_ovf", {31'd0, ovf}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        drive();
        run(140, cnt, last);
        chk("post_rst_cnt", cnt, 1);
        chk("post_rst_dat", last, 32'h7fff_8000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
